trng_ctrl: RTL

TRNG_CTRL -- requirements
Module: trng_ctrl

---
 rtl/trng_pkg.sv | 15 +
 rtl/trng_rct.sv | 50 +++++
 rtl/trng_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/trng_pkg.sv
// Shared definitions for the TRNG controller: FSM encoding and data widths.
package trng_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WARMUP  = 2'd1,
    ST_COLLECT = 2'd2,
    ST_ERROR   = 2'd3
  } trng_state_e;

  localparam int WORD_W         = 32;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = WORD_W / BYTE_W;

endpackage

// File: rtl/trng_rct.sv
// Repetition-count health test: flags a run of identical raw samples.
module trng_rct
  import trng_pkg::*;
#(
  parameter int CUTOFF = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              strobe,
  input  logic [BYTE_W-1:0] raw_byte,
  input  logic              clear,
  output logic              fail
);

  localparam logic [7:0] CUTOFF_L = 8'(CUTOFF);

  logic [BYTE_W-1:0] prev_reg;
  logic [7:0]        rep_cnt_reg;
  logic              have_prev_reg;
  logic [7:0]        rep_next;

  // Run length including the sample offered this cycle; saturates so it never wraps.
  always_comb begin
    rep_next = 8'd1;
    if (have_prev_reg && (raw_byte == prev_reg)) begin
      rep_next = (rep_cnt_reg == 8'hFF) ? rep_cnt_reg : rep_cnt_reg + 8'd1;
    end
  end

  // Failure is reported in the strobe cycle so the controller reacts on the next edge.
  assign fail = strobe && !clear && (rep_next >= CUTOFF_L);

  // Track the last sample and the current run length; clear forgets history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_reg      <= '0;
      rep_cnt_reg   <= '0;
      have_prev_reg <= 1'b0;
    end else if (clear) begin
      prev_reg      <= '0;
      rep_cnt_reg   <= '0;
      have_prev_reg <= 1'b0;
    end else if (strobe) begin
      prev_reg      <= raw_byte;
      rep_cnt_reg   <= rep_next;
      have_prev_reg <= 1'b1;
    end
  end

endmodule

// File: rtl/trng_ctrl.sv
// TRNG controller: STR warm-up, decimated sampling, word assembly and health test.
module trng_ctrl
  import trng_pkg::*;
#(
  parameter int DECIM      = 16,
  parameter int WARMUP     = 1024,
  parameter int RCT_CUTOFF = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [BYTE_W-1:0] raw_byte,
  output logic              str_run,
  output logic [WORD_W-1:0] rnd_data,
  output logic              rnd_valid,
  input  logic              rnd_ready,
  output logic              err,
  output logic [1:0]        state
);

  localparam logic [15:0] DECIM_LAST  = 16'(DECIM - 1);
  localparam logic [15:0] WARMUP_LAST = 16'(WARMUP - 1);

  trng_state_e       state_reg;
  logic [15:0]       cnt_reg;
  logic [1:0]        byte_cnt_reg;
  logic              asm_full_reg;
  logic [WORD_W-1:0] asm_reg;
  logic [WORD_W-1:0] rnd_data_reg;
  logic              rnd_valid_reg;
  logic              str_run_reg;
  logic              err_reg;

  logic              strobe;
  logic              pop;
  logic              rct_fail;
  logic              rct_clear;
  logic [WORD_W-1:0] word_next;

  assign strobe    = (state_reg == ST_COLLECT) && (cnt_reg == DECIM_LAST);
  assign pop       = rnd_valid_reg && rnd_ready;
  assign rct_clear = (state_reg != ST_COLLECT);
  assign word_next = {asm_reg[WORD_W-BYTE_W-1:0], raw_byte};

  assign str_run   = str_run_reg;
  assign rnd_data  = rnd_data_reg;
  assign rnd_valid = rnd_valid_reg;
  assign err       = err_reg;
  assign state     = state_reg;

  trng_rct #(
    .CUTOFF (RCT_CUTOFF)
  ) u_rct (
    .clk      (clk),
    .rst      (rst),
    .strobe   (strobe),
    .raw_byte (raw_byte),
    .clear    (rct_clear),
    .fail     (rct_fail)
  );

  // Main controller: state sequencing, sampling counter, assembler and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      byte_cnt_reg  <= '0;
      asm_full_reg  <= 1'b0;
      asm_reg       <= '0;
      rnd_data_reg  <= '0;
      rnd_valid_reg <= 1'b0;
      str_run_reg   <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      // A handshake empties the output register unless a new word refills it below.
      if (pop) rnd_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          cnt_reg <= '0;
          if (en) begin
            state_reg   <= ST_WARMUP;
            str_run_reg <= 1'b1;
          end
        end
        ST_WARMUP: begin
          if (!en) begin
            state_reg   <= ST_IDLE;
            str_run_reg <= 1'b0;
            cnt_reg     <= '0;
          end else if (cnt_reg == WARMUP_LAST) begin
            state_reg <= ST_COLLECT;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
        ST_COLLECT: begin
          if (!en) begin
            // Partial or stalled assembler contents are dropped; a pending output word stays.
            state_reg    <= ST_IDLE;
            str_run_reg  <= 1'b0;
            cnt_reg      <= '0;
            byte_cnt_reg <= '0;
            asm_full_reg <= 1'b0;
            asm_reg      <= '0;
          end else if (rct_fail) begin
            // Health failure wins over any word completing in the same cycle.
            state_reg     <= ST_ERROR;
            str_run_reg   <= 1'b0;
            err_reg       <= 1'b1;
            rnd_valid_reg <= 1'b0;
            cnt_reg       <= '0;
            byte_cnt_reg  <= '0;
            asm_full_reg  <= 1'b0;
            asm_reg       <= '0;
          end else begin
            cnt_reg <= strobe ? 16'd0 : cnt_reg + 16'd1;
            if (asm_full_reg) begin
              // Stalled complete word moves out as soon as the consumer pops.
              if (pop) begin
                rnd_data_reg  <= asm_reg;
                rnd_valid_reg <= 1'b1;
                asm_full_reg  <= 1'b0;
              end
            end else if (strobe) begin
              asm_reg <= word_next;
              if (byte_cnt_reg == 2'(BYTES_PER_WORD - 1)) begin
                byte_cnt_reg <= '0;
                if (!rnd_valid_reg || pop) begin
                  rnd_data_reg  <= word_next;
                  rnd_valid_reg <= 1'b1;
                end else begin
                  asm_full_reg <= 1'b1;
                end
              end else begin
                byte_cnt_reg <= byte_cnt_reg + 2'd1;
              end
            end
          end
        end
        ST_ERROR: begin
          if (!en) begin
            state_reg <= ST_IDLE;
            err_reg   <= 1'b0;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
